// File: rtl/iop_gpio_pkg.sv
// Shared definitions for the IOP GPIO responder.
// Word-index register offsets, transfer sizes and the byte-lane mask helper.
package iop_gpio_pkg;

    localparam logic [9:0] A_DATA   = 10'h000;
    localparam logic [9:0] A_DOUT   = 10'h001;
    localparam logic [9:0] A_OESET  = 10'h004;
    localparam logic [9:0] A_OECLR  = 10'h005;
    localparam logic [9:0] A_IESET  = 10'h008;
    localparam logic [9:0] A_IECLR  = 10'h009;
    localparam logic [9:0] A_ITSET  = 10'h00A;
    localparam logic [9:0] A_ITCLR  = 10'h00B;
    localparam logic [9:0] A_IPSET  = 10'h00C;
    localparam logic [9:0] A_IPCLR  = 10'h00D;
    localparam logic [9:0] A_ISTAT  = 10'h00E;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;

    function automatic logic [3:0] byte_mask(
        input logic [1:0] size,
        input logic [1:0] a
    );
        case (size)
            SZ_BYTE: byte_mask = 4'b0001 << a;
            SZ_HALF: byte_mask = a[1] ? 4'b1100 : 4'b0011;
            default: byte_mask = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/iop_gpio_sync.sv
// Two-flop pin synchroniser with a history stage for edge detection.
// rise/fall compare the synchronised level against the previous cycle.
module iop_gpio_sync #(
    parameter int WIDTH = 16
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] sync2,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] prev_q, prev_d;

    always_comb begin
        sync1_d = din;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign sync2 = sync2_q;
    assign rise  = sync2_q & ~prev_q;
    assign fall  = ~sync2_q & prev_q;

endmodule

// File: rtl/iop_gpio_port.sv
// GPIO peripheral on the IOP side of the AHB bridge: zero-wait register
// file, output enables and per-pin level/edge interrupts.
module iop_gpio_port
    import iop_gpio_pkg::*;
#(
    parameter int               WIDTH      = 16,
    parameter logic [WIDTH-1:0] DOUT_RESET = '0
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             IOSEL,
    input  logic             IOTRANS,
    input  logic [11:0]      IOADDR,
    input  logic             IOWRITE,
    input  logic [1:0]       IOSIZE,
    input  logic [31:0]      IOWDATA,
    output logic [31:0]      IORDATA,
    input  logic [WIDTH-1:0] PORTIN,
    output logic [WIDTH-1:0] PORTOUT,
    output logic [WIDTH-1:0] PORTEN,
    output logic [WIDTH-1:0] GPIOINT,
    output logic             COMBINT
);

    // Registers are held 32 bits wide; bits at or above WIDTH stay zero.
    localparam logic [31:0] PMASK = (WIDTH >= 32) ? 32'hFFFF_FFFF
                                  : ((32'h1 << WIDTH) - 32'h1);

    logic [31:0] dout_q, dout_d;
    logic [31:0] outen_q, outen_d;
    logic [31:0] inten_q, inten_d;
    logic [31:0] itype_q, itype_d;
    logic [31:0] ipol_q, ipol_d;
    logic [31:0] istat_q, istat_d;

    logic [WIDTH-1:0] sync2, rise, fall;
    logic [31:0] s2_w, rise_w, fall_w;
    logic        acc, wr;
    logic [9:0]  waddr;
    logic [3:0]  bm;
    logic [31:0] lanes, wd, clr, cond, rd, irq;

    iop_gpio_sync #(.WIDTH(WIDTH)) u_sync (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .din     (PORTIN),
        .sync2   (sync2),
        .rise    (rise),
        .fall    (fall)
    );

    always_comb begin
        s2_w   = '0;
        rise_w = '0;
        fall_w = '0;
        s2_w[WIDTH-1:0]   = sync2;
        rise_w[WIDTH-1:0] = rise;
        fall_w[WIDTH-1:0] = fall;
        acc   = IOSEL & IOTRANS;
        wr    = acc & IOWRITE;
        waddr = IOADDR[11:2];
        bm    = byte_mask(IOSIZE, IOADDR[1:0]);
        lanes = {{8{bm[3]}}, {8{bm[2]}}, {8{bm[1]}}, {8{bm[0]}}};
        wd    = IOWDATA & lanes & PMASK;
    end

    always_comb begin
        dout_d  = dout_q;
        outen_d = outen_q;
        inten_d = inten_q;
        itype_d = itype_q;
        ipol_d  = ipol_q;
        clr     = '0;
        if (wr) begin
            case (waddr)
                A_DOUT:  dout_d  = (dout_q & ~(lanes & PMASK)) | wd;
                A_OESET: outen_d = outen_q | wd;
                A_OECLR: outen_d = outen_q & ~wd;
                A_IESET: inten_d = inten_q | wd;
                A_IECLR: inten_d = inten_q & ~wd;
                A_ITSET: itype_d = itype_q | wd;
                A_ITCLR: itype_d = itype_q & ~wd;
                A_IPSET: ipol_d  = ipol_q | wd;
                A_IPCLR: ipol_d  = ipol_q & ~wd;
                A_ISTAT: clr     = wd;
                default: ;
            endcase
        end
        // A new hit always beats a same-cycle software clear.
        cond = (itype_q & ((ipol_q & rise_w) | (~ipol_q & fall_w)))
             | (~itype_q & ~(s2_w ^ ipol_q));
        istat_d = ((cond & inten_q) | (istat_q & ~clr)) & PMASK;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dout_q  <= {{(32 - WIDTH){1'b0}}, DOUT_RESET} & PMASK;
            outen_q <= '0;
            inten_q <= '0;
            itype_q <= '0;
            ipol_q  <= '0;
            istat_q <= '0;
        end else begin
            dout_q  <= dout_d;
            outen_q <= outen_d;
            inten_q <= inten_d;
            itype_q <= itype_d;
            ipol_q  <= ipol_d;
            istat_q <= istat_d;
        end
    end

    always_comb begin
        rd = '0;
        case (waddr)
            A_DATA:           rd = s2_w;
            A_DOUT:           rd = dout_q;
            A_OESET, A_OECLR: rd = outen_q;
            A_IESET, A_IECLR: rd = inten_q;
            A_ITSET, A_ITCLR: rd = itype_q;
            A_IPSET, A_IPCLR: rd = ipol_q;
            A_ISTAT:          rd = istat_q;
            default:          rd = '0;
        endcase
        IORDATA = acc ? rd : 32'h0;
        irq     = istat_q & inten_q;
    end

    assign PORTOUT = dout_q[WIDTH-1:0];
    assign PORTEN  = outen_q[WIDTH-1:0];
    assign GPIOINT = irq[WIDTH-1:0];
    assign COMBINT = |irq;

endmodule

// File: tb/tb_iop_gpio_port.sv
// Directed self-checking bench for iop_gpio_port (WIDTH=16).
// Inputs change on the falling edge; outputs are sampled away from rising edges.
module tb_iop_gpio_port;

    logic        HCLK;
    logic        HRESETn;
    logic        IOSEL;
    logic        IOTRANS;
    logic [11:0] IOADDR;
    logic        IOWRITE;
    logic [1:0]  IOSIZE;
    logic [31:0] IOWDATA;
    logic [31:0] IORDATA;
    logic [15:0] PORTIN;
    logic [15:0] PORTOUT;
    logic [15:0] PORTEN;
    logic [15:0] GPIOINT;
    logic        COMBINT;

    int total = 0;
    int bad   = 0;

    iop_gpio_port #(.WIDTH(16), .DOUT_RESET(16'h0000)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .IOSEL   (IOSEL),
        .IOTRANS (IOTRANS),
        .IOADDR  (IOADDR),
        .IOWRITE (IOWRITE),
        .IOSIZE  (IOSIZE),
        .IOWDATA (IOWDATA),
        .IORDATA (IORDATA),
        .PORTIN  (PORTIN),
        .PORTOUT (PORTOUT),
        .PORTEN  (PORTEN),
        .GPIOINT (GPIOINT),
        .COMBINT (COMBINT)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic bus_idle();
        IOSEL   = 1'b0;
        IOTRANS = 1'b0;
        IOWRITE = 1'b0;
        IOADDR  = 12'h0;
        IOSIZE  = 2'd2;
        IOWDATA = 32'h0;
    endtask

    task automatic bus_wr(input logic [11:0] a, input logic [1:0] sz,
                          input logic [31:0] d);
        @(negedge HCLK);
        IOSEL   = 1'b1;
        IOTRANS = 1'b1;
        IOWRITE = 1'b1;
        IOADDR  = a;
        IOSIZE  = sz;
        IOWDATA = d;
        @(posedge HCLK);
        #1;
        bus_idle();
    endtask

    task automatic bus_rd(input logic [11:0] a, output logic [31:0] d);
        @(negedge HCLK);
        IOSEL   = 1'b1;
        IOTRANS = 1'b1;
        IOWRITE = 1'b0;
        IOADDR  = a;
        IOSIZE  = 2'd2;
        #1;
        d = IORDATA;
        bus_idle();
    endtask

    task automatic test_reset();
        logic [31:0] r;
        HRESETn = 1'b0;
        PORTIN  = 16'hFFFF;
        bus_idle();
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        total++;
        if ({PORTOUT, PORTEN, GPIOINT, COMBINT} !== 49'h0) begin
            bad++;
            $display("FAIL reset_outputs: got out=%h en=%h int=%h comb=%b want 0",
                     PORTOUT, PORTEN, GPIOINT, COMBINT);
        end
        HRESETn = 1'b1;
        bus_rd(12'h000, r);
        total++;
        if (r !== 32'h0) begin
            bad++;
            $display("FAIL data_after_1_edge: got %h want 00000000", r);
        end
        bus_rd(12'h000, r);
        total++;
        if (r !== 32'h0000FFFF) begin
            bad++;
            $display("FAIL data_sync: got %h want 0000ffff", r);
        end
    endtask

    task automatic test_dataout();
        logic [31:0] r;
        bus_wr(12'h004, 2'd2, 32'h1234ABCD);
        bus_wr(12'h005, 2'd0, 32'h0000EE00);
        bus_rd(12'h004, r);
        total++;
        if (r !== 32'h0000EECD) begin
            bad++;
            $display("FAIL dataout_byte: got %h want 0000eecd", r);
        end
        total++;
        if (PORTOUT !== 16'hEECD) begin
            bad++;
            $display("FAIL portout: got %h want eecd", PORTOUT);
        end
        bus_wr(12'h006, 2'd1, 32'h55660000);
        bus_rd(12'h004, r);
        total++;
        if (r !== 32'h0000EECD) begin
            bad++;
            $display("FAIL dataout_upper_half: got %h want 0000eecd", r);
        end
    endtask

    task automatic test_outen();
        logic [31:0] r;
        bus_wr(12'h010, 2'd2, 32'h000000F0);
        bus_wr(12'h014, 2'd2, 32'h00000030);
        @(negedge HCLK);
        total++;
        if (PORTEN !== 16'h00C0) begin
            bad++;
            $display("FAIL porten: got %h want 00c0", PORTEN);
        end
        bus_rd(12'h010, r);
        total++;
        if (r !== 32'h000000C0) begin
            bad++;
            $display("FAIL outenset_rd: got %h want 000000c0", r);
        end
        bus_rd(12'h014, r);
        total++;
        if (r !== 32'h000000C0) begin
            bad++;
            $display("FAIL outenclr_rd: got %h want 000000c0", r);
        end
    endtask

    task automatic test_edge_int();
        logic [31:0] r;
        PORTIN = 16'h0000;
        bus_wr(12'h028, 2'd2, 32'h8);
        bus_wr(12'h030, 2'd2, 32'h8);
        bus_wr(12'h020, 2'd2, 32'h8);
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        PORTIN = 16'h0008;
        @(posedge HCLK);
        @(posedge HCLK);
        @(negedge HCLK);
        total++;
        if (GPIOINT !== 16'h0000) begin
            bad++;
            $display("FAIL edge_early: got %h want 0000", GPIOINT);
        end
        @(posedge HCLK);
        @(negedge HCLK);
        total++;
        if (GPIOINT !== 16'h0008 || COMBINT !== 1'b1) begin
            bad++;
            $display("FAIL edge_set: got int=%h comb=%b want 0008/1",
                     GPIOINT, COMBINT);
        end
        bus_rd(12'h038, r);
        total++;
        if (r !== 32'h8) begin
            bad++;
            $display("FAIL edge_status: got %h want 00000008", r);
        end
        bus_wr(12'h024, 2'd2, 32'h8);
        bus_rd(12'h038, r);
        total++;
        if (GPIOINT !== 16'h0000 || r !== 32'h8) begin
            bad++;
            $display("FAIL inten_mask: got int=%h stat=%h want 0000/8",
                     GPIOINT, r);
        end
        bus_wr(12'h020, 2'd2, 32'h8);
        @(negedge HCLK);
        total++;
        if (GPIOINT !== 16'h0008) begin
            bad++;
            $display("FAIL inten_reenable: got %h want 0008", GPIOINT);
        end
        bus_wr(12'h038, 2'd2, 32'h8);
        repeat (3) @(posedge HCLK);
        bus_rd(12'h038, r);
        total++;
        if (GPIOINT !== 16'h0000 || COMBINT !== 1'b0 || r !== 32'h0) begin
            bad++;
            $display("FAIL edge_clear: got int=%h comb=%b stat=%h want 0",
                     GPIOINT, COMBINT, r);
        end
    endtask

    task automatic test_level_int();
        logic [31:0] r;
        bus_wr(12'h030, 2'd2, 32'h20);
        PORTIN = 16'h0028;
        repeat (3) @(posedge HCLK);
        bus_wr(12'h020, 2'd2, 32'h20);
        @(posedge HCLK);
        for (int i = 0; i < 4; i++) begin
            @(negedge HCLK);
            IOSEL   = 1'b1;
            IOTRANS = 1'b1;
            IOWRITE = 1'b1;
            IOADDR  = 12'h038;
            IOSIZE  = 2'd2;
            IOWDATA = 32'h20;
            #1;
            total++;
            if (IORDATA !== 32'h20 || GPIOINT !== 16'h0020) begin
                bad++;
                $display("FAIL level_set_wins[%0d]: got stat=%h int=%h want 20",
                         i, IORDATA, GPIOINT);
            end
        end
        @(posedge HCLK);
        #1;
        bus_idle();
        PORTIN = 16'h0008;
        repeat (4) @(posedge HCLK);
        bus_wr(12'h038, 2'd2, 32'h20);
        repeat (2) @(posedge HCLK);
        bus_rd(12'h038, r);
        total++;
        if (r !== 32'h0 || GPIOINT !== 16'h0000) begin
            bad++;
            $display("FAIL level_clear: got stat=%h int=%h want 0", r, GPIOINT);
        end
    endtask

    task automatic test_idle_unmapped();
        logic [31:0] r;
        @(negedge HCLK);
        IOSEL   = 1'b1;
        IOTRANS = 1'b0;
        IOWRITE = 1'b1;
        IOADDR  = 12'h004;
        IOSIZE  = 2'd2;
        IOWDATA = 32'h0;
        #1;
        total++;
        if (IORDATA !== 32'h0) begin
            bad++;
            $display("FAIL idle_rdata: got %h want 00000000", IORDATA);
        end
        @(posedge HCLK);
        #1;
        bus_idle();
        bus_rd(12'h004, r);
        total++;
        if (r !== 32'h0000EECD || PORTOUT !== 16'hEECD) begin
            bad++;
            $display("FAIL idle_nowrite: got %h/%h want eecd", r, PORTOUT);
        end
        bus_rd(12'h0FC, r);
        total++;
        if (r !== 32'h0) begin
            bad++;
            $display("FAIL unmapped_rd: got %h want 00000000", r);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge HCLK);
        IOSEL   = 1'b1;
        IOTRANS = 1'b1;
        IOWRITE = 1'b1;
        IOADDR  = 12'h010;
        IOSIZE  = 2'd2;
        IOWDATA = 32'hFF;
        #2;
        HRESETn = 1'b0;
        #1;
        total++;
        if (PORTOUT !== 16'h0 || PORTEN !== 16'h0 || COMBINT !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: got out=%h en=%h comb=%b want 0",
                     PORTOUT, PORTEN, COMBINT);
        end
        bus_idle();
        @(posedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(negedge HCLK);
        total++;
        if (PORTEN !== 16'h0) begin
            bad++;
            $display("FAIL lost_write: got en=%h want 0000", PORTEN);
        end
    endtask

    initial begin
        test_reset();
        test_dataout();
        test_outen();
        test_edge_int();
        test_level_int();
        test_idle_unmapped();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
